// File: rtl/wb_commit_pkg.sv
// Shared definitions for the write-back commit slice.
// Holds the register bus and address widths, their zero/NOP constants,
// and the active levels of enables, reset and stall used across the core.
package wb_commit_pkg;

  localparam int reg_w   = 32;
  localparam int reg_aw  = 5;
  localparam int reg_num = 32;

  typedef logic [reg_w-1:0]  reg_bus_t;   // RegBus
  typedef logic [reg_aw-1:0] reg_addr_t;  // RegAddrBus

  localparam reg_bus_t  zero_word     = '0;
  localparam reg_addr_t nop_reg_addr  = '0;
  localparam logic      write_enable  = 1'b1;
  localparam logic      write_disable = 1'b0;
  localparam logic      rst_enable    = 1'b1;
  localparam logic      stop          = 1'b1;
  localparam logic      no_stop       = 1'b0;

endpackage

// File: rtl/wb_commit_if.sv
// WB-stage bus between the pipeline and the write-back commit unit.
// Handshake: there is no valid/ready pair. A WB-stage transaction is taken
// on every rising clk edge where rst=0 and stall_wb=0; while stall_wb=1 the
// upstream stage holds the wb_* fields stable and nothing is committed.
// Read requests (re/raddr) are answered combinationally in the same cycle.
//   master : pipeline side, drives WB fields, flush, stall and read requests
//   slave  : commit unit, returns GPR read data and HI/LO/LLbit values
interface wb_commit_if;
  import wb_commit_pkg::*;

  logic      stall_wb;
  logic      flush;
  reg_bus_t  wb_pc;
  reg_addr_t wb_wd;
  logic      wb_wreg;
  reg_bus_t  wb_wdata;
  reg_bus_t  wb_hi;
  reg_bus_t  wb_lo;
  logic      wb_whilo;
  logic      wb_LLbit_we;
  logic      wb_LLbit_value;
  logic      re1;
  logic      re2;
  reg_addr_t raddr1;
  reg_addr_t raddr2;
  reg_bus_t  rdata1;
  reg_bus_t  rdata2;
  reg_bus_t  hi_o;
  reg_bus_t  lo_o;
  logic      LLbit_o;

  modport master (
    output stall_wb, flush, wb_pc, wb_wd, wb_wreg, wb_wdata,
           wb_hi, wb_lo, wb_whilo, wb_LLbit_we, wb_LLbit_value,
           re1, re2, raddr1, raddr2,
    input  rdata1, rdata2, hi_o, lo_o, LLbit_o
  );

  modport slave (
    input  stall_wb, flush, wb_pc, wb_wd, wb_wreg, wb_wdata,
           wb_hi, wb_lo, wb_whilo, wb_LLbit_we, wb_LLbit_value,
           re1, re2, raddr1, raddr2,
    output rdata1, rdata2, hi_o, lo_o, LLbit_o
  );

endinterface

// File: rtl/wb_commit_gpr_file.sv
// gpr_file: 32 x 32-bit general purpose register file, 2 read / 1 write.
// $0 is never written and always reads zero. A write in flight this cycle
// is forwarded to a matching read port so readers see it with no hazard.
// Every register is cleared by the synchronous reset.
// Ports:
//   clk, rst              clock, synchronous active-high reset
//   we, waddr, wdata      write port (we already qualified by commit)
//   re1, raddr1, rdata1   read port 1 (combinational)
//   re2, raddr2, rdata2   read port 2 (combinational)
module gpr_file
  import wb_commit_pkg::*;
(
  input  logic      clk,
  input  logic      rst,
  input  logic      we,
  input  reg_addr_t waddr,
  input  reg_bus_t  wdata,
  input  logic      re1,
  input  reg_addr_t raddr1,
  output reg_bus_t  rdata1,
  input  logic      re2,
  input  reg_addr_t raddr2,
  output reg_bus_t  rdata2
);

  reg_bus_t regs [reg_num];

  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      for (int i = 0; i < reg_num; i++) regs[i] <= zero_word;
    end else if (we == write_enable && waddr != nop_reg_addr) begin
      regs[waddr] <= wdata;
    end
  end

  always_comb begin
    rdata1 = zero_word;
    if (rst == rst_enable || !re1 || raddr1 == nop_reg_addr) begin
      rdata1 = zero_word;
    end else if (we == write_enable && waddr == raddr1) begin
      rdata1 = wdata;
    end else begin
      rdata1 = regs[raddr1];
    end
  end

  always_comb begin
    rdata2 = zero_word;
    if (rst == rst_enable || !re2 || raddr2 == nop_reg_addr) begin
      rdata2 = zero_word;
    end else if (we == write_enable && waddr == raddr2) begin
      rdata2 = wdata;
    end else begin
      rdata2 = regs[raddr2];
    end
  end

endmodule

// File: rtl/wb_commit.sv
// wb_commit: write-back commit unit of the 5-stage MIPS core.
// Performs the architectural update for the instruction in WB (GPR, HI/LO,
// LLbit) and serves the ID-stage GPR reads and the HI/LO/LLbit values, all
// with same-cycle forwarding of the commit in progress.
// Optional feature: define WB_DEBUG_TRACE_EN to get the debug_wb_* commit
// trace ports; without it those ports and their logic do not exist.
// Ports:
//   clk, rst        clock, synchronous active-high reset
//   wb              wb_commit_if.slave: WB fields, stall/flush, read ports,
//                   rdata1/2, hi_o, lo_o, LLbit_o
//   debug_wb_*      commit trace (WB_DEBUG_TRACE_EN only)
module wb_commit
  import wb_commit_pkg::*;
(
  input  logic           clk,
  input  logic           rst,
  wb_commit_if.slave     wb
`ifdef WB_DEBUG_TRACE_EN
  ,
  output reg_bus_t       debug_wb_pc,
  output logic [3:0]     debug_wb_rf_wen,
  output reg_addr_t      debug_wb_rf_wnum,
  output reg_bus_t       debug_wb_rf_wdata
`endif
);

  logic     commit;
  logic     gpr_we;
  logic     hilo_we;
  logic     ll_we;
  reg_bus_t hi;
  reg_bus_t lo;
  logic     llbit;

  assign commit  = (rst != rst_enable) && (wb.stall_wb == no_stop);
  assign gpr_we  = commit && wb.wb_wreg;
  assign hilo_we = commit && wb.wb_whilo;
  assign ll_we   = commit && wb.wb_LLbit_we;

  gpr_file u_gpr_file (
    .clk    (clk),
    .rst    (rst),
    .we     (gpr_we),
    .waddr  (wb.wb_wd),
    .wdata  (wb.wb_wdata),
    .re1    (wb.re1),
    .raddr1 (wb.raddr1),
    .rdata1 (wb.rdata1),
    .re2    (wb.re2),
    .raddr2 (wb.raddr2),
    .rdata2 (wb.rdata2)
  );

  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      hi <= zero_word;
      lo <= zero_word;
    end else if (hilo_we) begin
      hi <= wb.wb_hi;
      lo <= wb.wb_lo;
    end
  end

  // flush beats a same-cycle LL/SC update and is not gated by stall: the
  // exception/eret always breaks the link.
  always_ff @(posedge clk) begin
    if (rst == rst_enable) begin
      llbit <= 1'b0;
    end else if (wb.flush) begin
      llbit <= 1'b0;
    end else if (ll_we) begin
      llbit <= wb.wb_LLbit_value;
    end
  end

  always_comb begin
    wb.hi_o = hi;
    wb.lo_o = lo;
    if (rst == rst_enable) begin
      wb.hi_o = zero_word;
      wb.lo_o = zero_word;
    end else if (hilo_we) begin
      wb.hi_o = wb.wb_hi;
      wb.lo_o = wb.wb_lo;
    end
  end

  always_comb begin
    wb.LLbit_o = llbit;
    if (rst == rst_enable || wb.flush) begin
      wb.LLbit_o = 1'b0;
    end else if (ll_we) begin
      wb.LLbit_o = wb.wb_LLbit_value;
    end
  end

`ifdef WB_DEBUG_TRACE_EN
  assign debug_wb_pc       = wb.wb_pc;
  assign debug_wb_rf_wen   = {4{gpr_we && (wb.wb_wd != nop_reg_addr)}};
  assign debug_wb_rf_wnum  = wb.wb_wd;
  assign debug_wb_rf_wdata = wb.wb_wdata;
`else
  // The PC only feeds the trace; keep it visibly consumed when the trace is off.
  logic unused_wb_pc;
  assign unused_wb_pc = ^wb.wb_pc;
`endif

endmodule

// File: tb/tb_wb_commit.sv
// Self-checking bench for wb_commit: a directed walk through the main
// behaviours with literal expectations, then randomized WB traffic checked
// every cycle against an architectural model (register array, HI/LO, LLbit).
module tb_wb_commit;
  import wb_commit_pkg::*;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  wb_commit_if bus ();

`ifdef WB_DEBUG_TRACE_EN
  logic [31:0] debug_wb_pc;
  logic [3:0]  debug_wb_rf_wen;
  logic [4:0]  debug_wb_rf_wnum;
  logic [31:0] debug_wb_rf_wdata;
`endif

  wb_commit dut (
    .clk               (clk),
    .rst               (rst),
    .wb                (bus)
`ifdef WB_DEBUG_TRACE_EN
    ,
    .debug_wb_pc       (debug_wb_pc),
    .debug_wb_rf_wen   (debug_wb_rf_wen),
    .debug_wb_rf_wnum  (debug_wb_rf_wnum),
    .debug_wb_rf_wdata (debug_wb_rf_wdata)
`endif
  );

  int n_checks = 0;
  int n_err    = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- architectural model ----------------
  logic [31:0] m_gpr [32];
  logic [31:0] m_hi, m_lo;
  logic        m_ll;
  logic        model_on = 1'b0;

  function automatic logic m_commit();
    return !rst && !bus.stall_wb;
  endfunction

  function automatic logic [31:0] m_read(input logic re, input logic [4:0] a);
    if (rst || !re || a == 5'd0) return 32'h0;
    if (m_commit() && bus.wb_wreg && bus.wb_wd == a) return bus.wb_wdata;
    return m_gpr[a];
  endfunction

  // Compare process: on each falling edge the inputs are stable, so check
  // the combinational outputs, then apply this cycle's commit to the model.
  always @(negedge clk) begin
    logic        c;
    logic [31:0] e_hi, e_lo;
    logic        e_ll;
    if (model_on || rst) begin
      c = m_commit();
      e_hi = rst ? 32'h0 : (c && bus.wb_whilo) ? bus.wb_hi : m_hi;
      e_lo = rst ? 32'h0 : (c && bus.wb_whilo) ? bus.wb_lo : m_lo;
      e_ll = (rst || bus.flush) ? 1'b0 : (c && bus.wb_LLbit_we) ? bus.wb_LLbit_value : m_ll;
      chk("rdata1", bus.rdata1, m_read(bus.re1, bus.raddr1));
      chk("rdata2", bus.rdata2, m_read(bus.re2, bus.raddr2));
      chk("hi_o", bus.hi_o, e_hi);
      chk("lo_o", bus.lo_o, e_lo);
      chk("LLbit_o", {31'h0, bus.LLbit_o}, {31'h0, e_ll});
`ifdef WB_DEBUG_TRACE_EN
      chk("debug_wb_pc", debug_wb_pc, bus.wb_pc);
      chk("debug_wb_rf_wen", {28'h0, debug_wb_rf_wen},
          (c && bus.wb_wreg && bus.wb_wd != 5'd0) ? 32'hF : 32'h0);
      chk("debug_wb_rf_wnum", {27'h0, debug_wb_rf_wnum}, {27'h0, bus.wb_wd});
      chk("debug_wb_rf_wdata", debug_wb_rf_wdata, bus.wb_wdata);
`endif
      if (rst) begin
        for (int i = 0; i < 32; i++) m_gpr[i] = 32'h0;
        m_hi = 32'h0;
        m_lo = 32'h0;
        m_ll = 1'b0;
        model_on = 1'b1;
      end else begin
        if (bus.flush) m_ll = 1'b0;
        else if (c && bus.wb_LLbit_we) m_ll = bus.wb_LLbit_value;
        if (c && bus.wb_wreg && bus.wb_wd != 5'd0) m_gpr[bus.wb_wd] = bus.wb_wdata;
        if (c && bus.wb_whilo) begin
          m_hi = bus.wb_hi;
          m_lo = bus.wb_lo;
        end
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic clear_inputs();
    bus.stall_wb = 1'b0;     bus.flush = 1'b0;
    bus.wb_pc = 32'h0;       bus.wb_wd = 5'd0;
    bus.wb_wreg = 1'b0;      bus.wb_wdata = 32'h0;
    bus.wb_hi = 32'h0;       bus.wb_lo = 32'h0;
    bus.wb_whilo = 1'b0;     bus.wb_LLbit_we = 1'b0;
    bus.wb_LLbit_value = 1'b0;
    bus.re1 = 1'b0;          bus.re2 = 1'b0;
    bus.raddr1 = 5'd0;       bus.raddr2 = 5'd0;
  endtask

  // Start a new cycle: move just past the rising edge, inputs back to idle.
  task automatic next_cycle();
    @(posedge clk);
    #1;
    rst = 1'b0;
    clear_inputs();
  endtask

  // Settle time before a literal check (still ahead of the falling edge).
  task automatic settle();
    #2;
  endtask

  logic [4:0]  r_wd;
  logic [31:0] r_pc, r_wdata, r_hi, r_lo;
  logic        r_wreg, r_whilo, r_llwe, r_llv;
  logic        held;

  initial begin
    clear_inputs();
    rst = 1'b1;
    repeat (2) @(posedge clk);

    // reset state
    next_cycle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd5;
    settle();
    chk("reset_rdata1", bus.rdata1, 32'h0);
    chk("reset_hi_o", bus.hi_o, 32'h0);
    chk("reset_LLbit_o", {31'h0, bus.LLbit_o}, 32'h0);

    // commit to $3 with same-cycle read (bypass), then stored read
    next_cycle();
    bus.wb_pc = 32'hBFC0_0010;
    bus.wb_wreg = 1'b1; bus.wb_wd = 5'd3; bus.wb_wdata = 32'hDEADBEEF;
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    settle();
    chk("bypass_rdata1", bus.rdata1, 32'hDEADBEEF);
`ifdef WB_DEBUG_TRACE_EN
    chk("trace_wen_f", {28'h0, debug_wb_rf_wen}, 32'hF);
`endif
    next_cycle();
    bus.re1 = 1'b1; bus.raddr1 = 5'd3;
    settle();
    chk("stored_rdata1", bus.rdata1, 32'hDEADBEEF);

    // write to $0 is dropped
    next_cycle();
    bus.wb_wreg = 1'b1; bus.wb_wd = 5'd0; bus.wb_wdata = 32'h1234;
    bus.re2 = 1'b1; bus.raddr2 = 5'd0;
    settle();
    chk("zero_rdata2", bus.rdata2, 32'h0);
`ifdef WB_DEBUG_TRACE_EN
    chk("trace_wen_0", {28'h0, debug_wb_rf_wen}, 32'h0);
`endif

    // HI/LO write held behind a 3-cycle stall
    for (int i = 0; i < 4; i++) begin
      next_cycle();
      bus.wb_whilo = 1'b1; bus.wb_hi = 32'h1; bus.wb_lo = 32'h2;
      bus.stall_wb = (i < 3);
      settle();
      chk("stall_hi_o", bus.hi_o, (i < 3) ? 32'h0 : 32'h1);
      chk("stall_lo_o", bus.lo_o, (i < 3) ? 32'h0 : 32'h2);
    end
    next_cycle();
    settle();
    chk("stored_hi_o", bus.hi_o, 32'h1);
    chk("stored_lo_o", bus.lo_o, 32'h2);

    // LL sets the link, flush beats a simultaneous LLbit write
    next_cycle();
    bus.wb_LLbit_we = 1'b1; bus.wb_LLbit_value = 1'b1;
    settle();
    chk("ll_set", {31'h0, bus.LLbit_o}, 32'h1);
    next_cycle();
    bus.flush = 1'b1; bus.wb_LLbit_we = 1'b1; bus.wb_LLbit_value = 1'b1;
    settle();
    chk("ll_flush", {31'h0, bus.LLbit_o}, 32'h0);
    next_cycle();
    settle();
    chk("ll_after_flush", {31'h0, bus.LLbit_o}, 32'h0);

    // disabled read port returns 0 even for a populated register
    next_cycle();
    bus.wb_wreg = 1'b1; bus.wb_wd = 5'd7; bus.wb_wdata = 32'h55;
    next_cycle();
    bus.re1 = 1'b0; bus.raddr1 = 5'd7;
    bus.re2 = 1'b1; bus.raddr2 = 5'd7;
    settle();
    chk("re1_off", bus.rdata1, 32'h0);
    chk("re2_on", bus.rdata2, 32'h55);

    // randomized traffic; WB fields held while stalled
    held = 1'b0;
    for (int n = 0; n < 600; n++) begin
      @(posedge clk);
      #1;
      if (!held) begin
        r_pc    = $urandom;
        r_wd    = 5'($urandom_range(0, 7));
        r_wreg  = ($urandom_range(0, 3) != 0);
        r_wdata = $urandom;
        r_whilo = ($urandom_range(0, 3) == 0);
        r_hi    = $urandom;
        r_lo    = $urandom;
        r_llwe  = ($urandom_range(0, 4) == 0);
        r_llv   = 1'($urandom_range(0, 1));
      end
      rst = ($urandom_range(0, 80) == 0);
      bus.stall_wb = ($urandom_range(0, 3) == 0);
      held = bus.stall_wb && !rst;
      bus.flush = ($urandom_range(0, 9) == 0);
      bus.wb_pc = r_pc;       bus.wb_wd = r_wd;
      bus.wb_wreg = r_wreg;   bus.wb_wdata = r_wdata;
      bus.wb_whilo = r_whilo; bus.wb_hi = r_hi; bus.wb_lo = r_lo;
      bus.wb_LLbit_we = r_llwe; bus.wb_LLbit_value = r_llv;
      bus.re1 = ($urandom_range(0, 4) != 0);
      bus.re2 = ($urandom_range(0, 4) != 0);
      bus.raddr1 = ($urandom_range(0, 1) != 0) ? r_wd : 5'($urandom_range(0, 7));
      bus.raddr2 = ($urandom_range(0, 1) != 0) ? r_wd : 5'($urandom_range(0, 31));
    end

    next_cycle();
    @(posedge clk);
    #1;
    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/wb_commit.md
# wb_commit

Write-back commit unit for the 5-stage MIPS core: consumes the WB-stage register outputs and performs the architectural state update, i.e. GPR write, HI/LO write and LLbit update. Provides the ID-stage GPR read ports and the MEM/EX-stage HI/LO/LLbit read values, each with same-cycle WB bypass. Optionally drives the commit trace used by the functional test harness.

## Interface
- No parameters; widths fixed by the shared package: 32-bit data, 5-bit register address.
- Reset: rst, synchronous, active-high. Clock: clk.
- clk  in  1  clock
- rst  in  1  synchronous reset, active-high
- stall_wb  in  1  WB stage stalled (stall bit 5); suppresses commit
- flush  in  1  pipeline flush (exception/eret); clears LLbit
- wb_pc  in  32  PC of instruction in WB
- wb_wd  in  5  GPR destination
- wb_wreg  in  1  GPR write enable
- wb_wdata  in  32  GPR write data
- wb_hi, wb_lo  in  32 each  HI/LO write data
- wb_whilo  in  1  HI/LO write enable
- wb_LLbit_we  in  1  LLbit write enable
- wb_LLbit_value  in  1  LLbit write value
- re1, re2  in  1 each  read-port enables
- raddr1, raddr2  in  5 each  read addresses
- rdata1, rdata2  out  32 each  GPR read data (combinational)
- hi_o, lo_o  out  32 each  HI/LO current value (bypassed)
- LLbit_o  out  1  LLbit current value (bypassed)
- debug_wb_pc  out  32  committed PC (trace only)
- debug_wb_rf_wen  out  4  byte write-enables of GPR commit (trace only)
- debug_wb_rf_wnum  out  5  committed GPR number (trace only)
- debug_wb_rf_wdata  out  32  committed GPR data (trace only)

## Operation
- commit = !rst & !stall_wb. All state updates are gated by commit at posedge clk.
- GPR: if commit & wb_wreg & wb_wd != 0, then gpr[wb_wd] <= wb_wdata. $0 is never written and always reads 0.
- Read port n: reN=0 gives 0; raddrN=0 gives 0; else if commit & wb_wreg & wb_wd==raddrN, gives wb_wdata (bypass); else gpr[raddrN].
- HI/LO: if commit & wb_whilo, hi<=wb_hi and lo<=wb_lo. hi_o/lo_o use the same bypass rule as the GPR read ports.
- LLbit: priority order is rst, then flush, then write. flush=1 sets LLbit<=0 regardless of wb_LLbit_we. Else if commit & wb_LLbit_we, LLbit<=wb_LLbit_value.
- LLbit_o: flush=1 gives 0. Else if commit & wb_LLbit_we, gives wb_LLbit_value. Else the stored LLbit.
- flush does not cancel the GPR/HI/LO commit of the instruction currently in WB. That instruction precedes the faulting one; the WB register itself is bubbled on the following cycle.
- Reset: hi=0, lo=0, LLbit=0, and all gpr=0. GPR clear happens over the synchronous reset cycle; rst held for at least 1 cycle is sufficient.

## Timing
- Write-to-storage latency: 1 clk. Read ports, hi_o/lo_o/LLbit_o and bypass are purely combinational, so there are 0 cycles of read-after-write hazard.
- Output values during rst=1: rdata1/2=0, hi_o=lo_o=0, LLbit_o=0, debug_wb_rf_wen=0, debug_wb_pc=wb_pc.
- stall_wb held for N cycles: no state change and no trace enable for N cycles. The WB inputs are held upstream and commit exactly once, on the first cycle with stall_wb=0.
- Simultaneous flush & wb_LLbit_we=1 (value 1): stored LLbit=0 and LLbit_o=0.
- Simultaneous wb_wreg to addr k and read of k on both ports: both ports return wb_wdata.
- rst asserted mid-stall: state resets at the next edge; stall is irrelevant.

## Configuration
- WB_DEBUG_TRACE_EN defined: the debug_wb_* ports exist.
  - debug_wb_pc=wb_pc.
  - debug_wb_rf_wen = {4{commit & wb_wreg & (wb_wd!=0)}}.
  - debug_wb_rf_wnum=wb_wd and debug_wb_rf_wdata=wb_wdata.
  - All trace outputs are combinational.
- Not defined: the four debug_wb_* ports are absent, and no trace logic is synthesized.

## Structure
- Shared package/header holds RegBus (32), RegAddrBus (5), ZeroWord, NOPRegAddr, WriteEnable/WriteDisable, RstEnable, Stop/NoStop.
- One sub-module, gpr_file: 32x32, 2 read / 1 write, $0 hardwired, with internal bypass.
- HI/LO, LLbit and trace logic stay in wb_commit.

## Test plan
- Reset 2 cycles, then read raddr1=5, hi_o, LLbit_o -> 0, 0, 0.
- Commit wb_wd=3, wb_wdata=0xDEADBEEF with raddr1=3 in the same cycle -> rdata1=0xDEADBEEF that cycle (bypass) and the next cycle (stored); with trace enabled, debug_wb_rf_wen=4'hF.
- Write wb_wd=0, data 0x1234 -> raddr2=0 reads 0, debug_wb_rf_wen=0.
- wb_whilo=1 with hi=0x1, lo=0x2 while stall_wb=1 for 3 cycles, then stall_wb=0 -> hi_o/lo_o stay at their old values for the 3 stalled cycles; they read 0x1/0x2 from the release cycle (bypass) and afterwards (stored).
- LL commit with LLbit value 1 -> LLbit_o=1. Then flush=1 in the same cycle as another LLbit_we=1 -> LLbit_o=0 that cycle and 0 stored afterwards.
- re1=0 with raddr1=7 holding 0x55 -> rdata1=0.
